// File: rtl/message_reader.sv
// message_reader: walks the character ROM from address 0 and presents each
// byte on a valid/ready stream. After each accepted character it waits a
// programmable number of idle cycles. A 8'h00 byte ends the pass early.
// In loop mode the pass restarts at address 0 without returning to idle.
module message_reader #(
   parameter int MSG_LEN  = 16,
   parameter int TICK_DIV = 25_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       loop,
   output logic [3:0] addr,
   input  logic [7:0] rom_data,
   output logic [7:0] char_out,
   output logic       char_valid,
   input  logic       char_ready,
   output logic       busy,
   output logic       done
);

   // Tick counter runs 0..TICK_DIV-1 while pacing, so TICK_DIV cycles per gap.
   localparam int TW = $clog2(TICK_DIV + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [3:0]    ADDR_LAST = 4'(MSG_LEN - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_SEND  = 3'd2;
   localparam logic [2:0] S_PACE  = 3'd3;
   localparam logic [2:0] S_END   = 3'd4;

   logic [2:0]    state_r;
   logic [2:0]    state_s;
   logic [3:0]    addr_r;
   logic [3:0]    addr_s;
   logic [7:0]    char_r;
   logic [7:0]    char_s;
   logic [TW-1:0] tick_r;
   logic [TW-1:0] tick_s;
   logic          valid_r;
   logic          busy_r;
   logic          done_r;

   assign addr       = addr_r;
   assign char_out   = char_r;
   assign char_valid = valid_r;
   assign busy       = busy_r;
   assign done       = done_r;

   // Next-state, address, character and tick counter computation.
   always_comb begin
      state_s = state_r;
      addr_s  = addr_r;
      char_s  = char_r;
      tick_s  = tick_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               addr_s  = 4'd0;
               state_s = S_FETCH;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_FETCH: begin
            // ROM output is combinational from addr, so latch it directly.
            char_s = rom_data;
            if (rom_data == 8'h00) begin
               state_s = S_END;
            end else begin
               state_s = S_SEND;
            end
         end
         S_SEND: begin
            // char_out is untouched here, so it stays stable under backpressure.
            if (char_ready) begin
               tick_s  = {TW{1'b0}};
               state_s = S_PACE;
            end else begin
               state_s = S_SEND;
            end
         end
         S_PACE: begin
            if (tick_r == TICK_LAST) begin
               tick_s = {TW{1'b0}};
               if (addr_r == ADDR_LAST) begin
                  state_s = S_END;
               end else begin
                  addr_s  = addr_r + 4'd1;
                  state_s = S_FETCH;
               end
            end else begin
               tick_s  = tick_r + TW'(1);
               state_s = S_PACE;
            end
         end
         S_END: begin
            if (loop) begin
               addr_s  = 4'd0;
               state_s = S_FETCH;
            end else begin
               // addr keeps its last value in idle.
               state_s = S_IDLE;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // State registers; status outputs are registered decodes of the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= S_IDLE;
         addr_r  <= 4'd0;
         char_r  <= 8'h00;
         tick_r  <= {TW{1'b0}};
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         addr_r  <= addr_s;
         char_r  <= char_s;
         tick_r  <= tick_s;
         valid_r <= (state_s == S_SEND);
         busy_r  <= (state_s != S_IDLE);
         done_r  <= (state_s == S_END);
      end
   end

endmodule

// File: doc/message_reader.md
# message_reader

Sequential reader for the 16-entry character ROM (`messagestorage`). On `start`, it walks the ROM addresses in order and latches each returned ASCII byte. It presents each byte on a valid/ready character stream, paced by a programmable tick divider. It sits between `messagestorage` and the downstream display driver, and is the only block that drives the ROM address.

## Interface
- `MSG_LEN`, default 16: number of ROM entries to read per pass; legal range is 1..16.
- `TICK_DIV`, default 25_000_000: number of idle cycles after each accepted character; must be ≥1. The tick counter is `$clog2(TICK_DIV+1)` bits wide.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: begins a pass when sampled high in IDLE; ignored otherwise.
- `loop`, input, 1: sampled in END; when high, the block restarts at address 0 instead of returning to IDLE.
- `addr`, output, 4: ROM address, registered.
- `rom_data`, input, 8: ROM output, combinational from `addr` (valid in the same cycle).
- `char_out`, output, 8: current character, registered.
- `char_valid`, output, 1: `char_out` is valid.
- `char_ready`, input, 1: the consumer accepts the character when `char_valid` and `char_ready` are both high on a clock edge.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse at the end of each pass.

## Operation
- States: IDLE, FETCH, SEND, PACE, END.
- IDLE
  - `busy`=0.
  - `start`=1 → `addr`←0, next state FETCH.
- FETCH (exactly 1 cycle)
  - `char_out`←`rom_data`.
  - If `rom_data`==8'h00 (terminator): next state END; no character is sent.
  - Otherwise: next state SEND.
- SEND
  - `char_valid`=1; `char_out` is held stable until the handshake completes.
  - On handshake: clear the tick counter, next state PACE.
  - `char_ready` has no effect outside SEND.
- PACE
  - Count `TICK_DIV` cycles.
  - On the last cycle: if `addr`==`MSG_LEN`-1, next state END; otherwise `addr`←`addr`+1, next state FETCH.
- END (exactly 1 cycle)
  - `done`=1.
  - `loop`=1 → `addr`←0, next state FETCH, `busy` stays 1.
  - `loop`=0 → next state IDLE, `addr` holds its last value.
- `start` received while `busy`=1 is ignored and is not queued.
- `addr` never exceeds `MSG_LEN`-1, so there is no 4-bit wrap.
- With `MSG_LEN`=16, the last address is 15 and the next pass restarts at 0 only through END.
- Reset asserted at any point, including mid-SEND, forces the following values immediately (asynchronously):
  - IDLE, `addr`=0, `char_out`=8'h00, `char_valid`=0, `busy`=0, `done`=0, tick counter=0.
  - No partial character is emitted after reset deasserts.

## Timing
- Reset values: `addr`=0, `char_out`=0, `char_valid`=0, `busy`=0, `done`=0.
- `start` sampled at edge 0 → FETCH during cycle 1 → `char_valid`=1 from cycle 2.
- With `char_ready` held high, the character period is 1 (FETCH) + 1 (SEND) + `TICK_DIV` (PACE) = `TICK_DIV`+2 cycles.
- Backpressure adds one cycle per cycle of `char_ready`=0 in SEND; there is no loss or duplication.
- From the last PACE cycle, `done` rises one cycle later. In loop mode, the next FETCH follows `done` directly.
- A terminator at address k: FETCH(k) → END in the next cycle. Characters 0..k-1 are sent; nothing at or after k is sent.

## Test plan
- Full pass: bench ROM holds "HELLO_FPGA_2024!", `TICK_DIV`=4, `char_ready`=1, `start` pulsed → expect:
  - 16 handshakes, in order, 6 cycles apart.
  - `addr` 0..15.
  - `done` one cycle after the last PACE cycle, then `busy`=0.
- Terminator: ROM has 8'h00 at address 5 → expect:
  - exactly 5 characters ("HELLO").
  - `done` 1 cycle after FETCH(5).
  - `addr` stays 5 in IDLE.
- Backpressure: `char_ready` low for 3 cycles on each character → expect:
  - `char_out` stable while waiting.
  - character period 9 cycles.
  - identical 16-character sequence.
- Loop: `loop`=1 → after 'H'..'!', `done` pulses and 'H' follows at `addr`=0 with no IDLE cycle. Drop `loop` before the next END → the block returns to IDLE after the second pass.
- Start while busy: pulse `start` during the 3rd character → expect no restart and exactly 16 characters.
- Reset mid-SEND: assert `reset` while `char_valid`=1 on the 7th character → expect all outputs 0 immediately. A new `start` after release → first character is 'H' from `addr`=0.
